// File: rtl/des_dec_key_sched_if.sv
// Key-in / subkey-out handshake bundle for des_dec_key_sched.
// DES_KS_ENC_MODE_EN adds the enc select sampled with the key.
interface des_dec_key_sched_if;
  logic        key_valid;
  logic        key_ready;
  logic [0:63] key;
  logic        sk_valid;
  logic        sk_ready;
  logic [0:47] subkey;
  logic [3:0]  sk_round;
  logic        sk_last;
`ifdef DES_KS_ENC_MODE_EN
  logic        enc;

  modport master (
    output key_valid, key, sk_ready, enc,
    input  key_ready, sk_valid, subkey, sk_round, sk_last
  );
  modport slave (
    input  key_valid, key, sk_ready, enc,
    output key_ready, sk_valid, subkey, sk_round, sk_last
  );
`else
  modport master (
    output key_valid, key, sk_ready,
    input  key_ready, sk_valid, subkey, sk_round, sk_last
  );
  modport slave (
    input  key_valid, key, sk_ready,
    output key_ready, sk_valid, subkey, sk_round, sk_last
  );
`endif
endinterface

// File: rtl/des_dec_key_sched.sv
// DES key schedule streaming K16..K1 (decrypt order), one per cycle.
// DES_KS_ENC_MODE_EN adds enc=1 to stream K1..K16 instead.
module des_dec_key_sched (
  input  logic              clk,
  input  logic              rst_n,
  des_dec_key_sched_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(i)] = k[6'(PC1_T[i] - 1)];
    return r;
  endfunction

  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(i)] = cd[6'(PC2_T[i] - 1)];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 (index 0, 1, 8, 15) shift by one.
  function automatic logic single(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] x, input logic two);
    return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
  endfunction

`ifdef DES_KS_ENC_MODE_EN
  function automatic logic [0:27] rotl(input logic [0:27] x, input logic two);
    return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
  endfunction

  logic enc_q, enc_d;
`endif

  state_e      state_q, state_d;
  logic [0:27] c_q, c_d, d_q, d_d;
  logic [0:47] sk_q, sk_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        last_q, last_d;
  logic [0:55] pc1_w;

  assign pc1_w = pc1(bus.key);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    last_d  = last_q;
`ifdef DES_KS_ENC_MODE_EN
    enc_d   = enc_q;
`endif
    unique case (state_q)
      IDLE: if (bus.key_valid) begin
        state_d = RUN;
        c_d     = pc1_w[0:27];
        d_d     = pc1_w[28:55];
        rnd_d   = 4'd15;
        last_d  = 1'b0;
`ifdef DES_KS_ENC_MODE_EN
        enc_d   = bus.enc;
        if (bus.enc) begin
          c_d   = rotl(pc1_w[0:27], 1'b0);
          d_d   = rotl(pc1_w[28:55], 1'b0);
          rnd_d = 4'd0;
        end
`endif
      end
      RUN: if (bus.sk_ready) begin
        if (last_q) begin
          state_d = IDLE;
        end else begin
          c_d    = rotr(c_q, !single(rnd_q));
          d_d    = rotr(d_q, !single(rnd_q));
          rnd_d  = rnd_q - 4'd1;
          last_d = (rnd_q == 4'd1);
`ifdef DES_KS_ENC_MODE_EN
          if (enc_q) begin
            c_d    = rotl(c_q, !single(rnd_q + 4'd1));
            d_d    = rotl(d_q, !single(rnd_q + 4'd1));
            rnd_d  = rnd_q + 4'd1;
            last_d = (rnd_q == 4'd14);
          end
`endif
        end
      end
    endcase
    // sk_q always tracks PC-2 of the stored C,D pair.
    sk_d = pc2({c_d, d_d});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      sk_q    <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
`ifdef DES_KS_ENC_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      sk_q    <= sk_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
`ifdef DES_KS_ENC_MODE_EN
      enc_q   <= enc_d;
`endif
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.sk_valid  = (state_q == RUN);
  assign bus.subkey    = sk_q;
  assign bus.sk_round  = rnd_q;
  assign bus.sk_last   = last_q;
endmodule
